// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle RV32I sequencing controller:
// the FSM state enum, the opcodes it recognises, the ALUOp and
// ALUControl codes, and the select encodings driven onto the datapath.
// Also provides imm_src_of(), the opcode-only immediate-format decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_e;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALUOp: what the current state asks of the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Immediate format depends only on the opcode; unknown opcodes fall to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_op_dec.sv
// alu_op_dec
// Purely combinational ALU control decoder.
// Ports:
//   alu_op_i      [1:0]  ALUOp requested by the controller state
//   op5_i                opcode bit 5 (1 for R-type, 0 for I-type ALU)
//   funct3_i      [2:0]  IR[14:12]
//   funct7b5_i           IR[30]
//   alu_control_o [2:0]  operation for the shared ALU
module alu_op_dec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // IR[30] only means sub for R-type; addi with IR[30]=1 stays add
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Sequencing controller for the multicycle RV32I core: steps one
// instruction through fetch/decode/execute/memory/writeback and drives
// the datapath enables and selects. Moore outputs from the state register,
// except pc_write (zero, mem_ready) and ir_write (mem_ready).
// Ports:
//   clk, reset (async, active-high)
//   op[6:0], funct3[2:0], funct7b5  instruction fields from the IR
//   zero       ALU zero flag (branch decision)
//   mem_ready  memory completes its access this cycle
//   pc_write, adr_src, mem_write, ir_write, result_src[1:0],
//   alu_src_a[1:0], alu_src_b[1:0], reg_write, imm_src[1:0],
//   alu_control[2:0], illegal_instr
// Configuration macro: MC_CTRL_ILLEGAL_TRAP_EN
//   defined   - unknown opcode enters TRAP and raises sticky illegal_instr
//   undefined - unknown opcode behaves as a nop, illegal_instr tied 0
module multicycle_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_e     state_q;
    logic [1:0] alu_op;
    logic       pc_write_raw;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH:    if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_R:         state_q <= S_EXECUTER;
                        OP_I:         state_q <= S_EXECUTEI;
                        OP_BEQ:       state_q <= S_BEQ;
                        OP_JAL:       state_q <= S_JAL;
                        default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                            state_q   <= S_TRAP;
                            illegal_q <= 1'b1;
`else
                            state_q <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEMADR:   state_q <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWB:    state_q <= S_FETCH;
                S_MEMWRITE: if (mem_ready) state_q <= S_FETCH;
                S_EXECUTER: state_q <= S_ALUWB;
                S_EXECUTEI: state_q <= S_ALUWB;
                S_ALUWB:    state_q <= S_FETCH;
                S_BEQ:      state_q <= S_FETCH;
                S_JAL:      state_q <= S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_TRAP:     state_q <= S_TRAP;
`endif
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write_raw  = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                alu_op       = ALUOP_SUB;
                pc_write_raw = zero;
            end
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_raw = 1'b1;
            end
            default: ; // TRAP: everything idle
        endcase
    end

    // Reset parks the FSM in FETCH, where mem_ready would otherwise
    // pass straight through to ir_write/pc_write; hold all enables off.
    assign pc_write  = pc_write_raw  & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign reg_write = reg_write_raw & ~reset;

    assign imm_src = imm_src_of(op);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    alu_op_dec u_alu_op_dec (
        .alu_op_i      (alu_op),
        .op5_i         (op[5]),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Drives whole instructions (with chosen memory stall counts) into the
// controller and compares every cycle's outputs against an
// instruction-level reference built from the phase sequence of each
// instruction class.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [16:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .reg_write     (reg_write),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, reg_write, alu_control, illegal_instr, imm_src};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
        end
    endtask

    // Expected output bundle for one cycle (imm_src is appended separately).
    function automatic logic [14:0] ev(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic rw, input logic [2:0] alu,
                                       input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, rw, alu, ill};
    endfunction

    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == SW)  return 2'b01;
        if (o == BEQ) return 2'b10;
        if (o == JAL) return 2'b11;
        return 2'b00;
    endfunction

    // RV32I meaning of the funct fields for register and immediate ALU ops.
    function automatic logic [2:0] alu_model(input logic is_reg, input logic [2:0] f3,
                                             input logic f7);
        case (f3)
            3'b000:  return (is_reg && f7) ? A_SUB : A_ADD;
            3'b010:  return A_SLT;
            3'b110:  return A_OR;
            3'b111:  return A_AND;
            default: return A_ADD;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    typedef struct packed {
        logic        mr;
        logic        z;
        logic [14:0] e;
    } cyc_t;

    cyc_t q[$];

    task automatic push(input logic mr, input logic z, input logic [14:0] e);
        q.push_back({mr, z, e});
    endtask

    // Reset / idle-FETCH view with every enable off
    function automatic logic [14:0] fetch_idle();
        return ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0);
    endfunction

    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic zb, input int fs, input int ms,
                             input int trap_cycles);
        cyc_t c;
        q.delete();
        for (int i = 0; i < fs; i++) push(0, rb(), fetch_idle());
        push(1, rb(), ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, A_ADD, 0));
        push(rb(), rb(), ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, A_ADD, 0));
        case (o)
            LW: begin
                push(rb(), rb(), ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0));
                for (int i = 0; i < ms; i++) push(0, rb(), ev(0, 1, 0, 0, 0, 0, 0, 0, A_ADD, 0));
                push(1, rb(), ev(0, 1, 0, 0, 0, 0, 0, 0, A_ADD, 0));
                push(rb(), rb(), ev(0, 0, 0, 0, 2'b01, 0, 0, 1, A_ADD, 0));
            end
            SW: begin
                push(rb(), rb(), ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD, 0));
                for (int i = 0; i < ms; i++) push(0, rb(), ev(0, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0));
                push(1, rb(), ev(0, 1, 1, 0, 0, 0, 0, 0, A_ADD, 0));
            end
            RT: begin
                push(rb(), rb(), ev(0, 0, 0, 0, 0, 2'b10, 2'b00, 0, alu_model(1, f3, f7), 0));
                push(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 1, A_ADD, 0));
            end
            IT: begin
                push(rb(), rb(), ev(0, 0, 0, 0, 0, 2'b10, 2'b01, 0, alu_model(0, f3, f7), 0));
                push(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 1, A_ADD, 0));
            end
            BEQ: push(rb(), zb, ev(zb, 0, 0, 0, 0, 2'b10, 2'b00, 0, A_SUB, 0));
            JAL: begin
                push(rb(), rb(), ev(1, 0, 0, 0, 0, 2'b01, 2'b10, 0, A_ADD, 0));
                push(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 1, A_ADD, 0));
            end
            default: begin
                // Unknown opcode: either a trap that holds, or straight back to fetch
                for (int i = 0; i < trap_cycles; i++)
                    push(rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, A_ADD, 1));
            end
        endcase
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            op        = o;
            funct3    = f3;
            funct7b5  = f7;
            zero      = c.z;
            mem_ready = c.mr;
            #1;
            check(tag, 32'(obs), 32'({c.e, imm_model(o)}));
        end
    endtask

    // Assert reset at a negedge, confirm the quiet FETCH view, release
    // with mem_ready low so the next instruction starts cleanly in FETCH.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check(tag, 32'(obs), 32'({fetch_idle(), imm_model(op)}));
        @(negedge clk);
        #1;
        check({tag, "_hold"}, 32'(obs), 32'({fetch_idle(), imm_model(op)}));
        reset     = 1'b0;
        mem_ready = 1'b0;
    endtask

    logic [6:0] kinds[7];
    int         trap_n;

    initial begin
        kinds[0] = LW; kinds[1] = SW; kinds[2] = RT; kinds[3] = IT;
        kinds[4] = BEQ; kinds[5] = JAL; kinds[6] = 7'b0110111;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        trap_n = 3;
`else
        trap_n = 0;
`endif
        reset     = 1'b1;
        op        = RT;
        funct3    = 3'b000;
        funct7b5  = 1'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        pulse_reset("reset");

        // Directed cases
        run_instr("add",      RT,  3'b000, 0, 0, 0, 0, 0);
        run_instr("sub",      RT,  3'b000, 1, 0, 0, 0, 0);
        run_instr("and",      RT,  3'b111, 0, 0, 0, 0, 0);
        run_instr("or",       RT,  3'b110, 1, 0, 0, 0, 0);
        run_instr("slt",      RT,  3'b010, 0, 0, 0, 0, 0);
        run_instr("addi_ir30", IT, 3'b000, 1, 0, 0, 0, 0);
        run_instr("lw_stall2", LW, 3'b010, 0, 0, 0, 2, 0);
        run_instr("beq_taken", BEQ, 3'b000, 0, 1, 0, 0, 0);
        run_instr("beq_not",  BEQ, 3'b000, 0, 0, 0, 0, 0);
        run_instr("sw_stall1", SW, 3'b010, 0, 0, 0, 1, 0);
        run_instr("jal",      JAL, 3'b000, 0, 0, 1, 0, 0);
        run_instr("fetch_stall", RT, 3'b000, 0, 0, 2, 0, 0);

        // Reset in the middle of a load: nothing of it may complete
        @(negedge clk);
        op = LW; funct3 = 3'b010; mem_ready = 1'b1;   // FETCH
        @(negedge clk);                                // DECODE
        @(negedge clk);                                // MEMADR
        @(negedge clk);                                // MEMREAD
        mem_ready = 1'b0;
        #1;
        check("lw_memread", 32'(obs), 32'({ev(0, 1, 0, 0, 0, 0, 0, 0, A_ADD, 0), 2'b00}));
        pulse_reset("reset_mid");
        run_instr("after_rst", SW, 3'b010, 0, 0, 0, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            int k;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            k = $urandom_range(0, 5);
`else
            k = $urandom_range(0, 6);
`endif
            run_instr("rand", kinds[k], 3'($urandom_range(0, 7)), rb(), rb(),
                      $urandom_range(0, 2), $urandom_range(0, 2), trap_n);
        end

        // Unknown opcode: trap (sticky until reset) or nop
        run_instr("unknown", 7'b0000000, 3'b000, 0, 0, 0, 0, trap_n);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        pulse_reset("reset_trap");
`endif
        run_instr("post_unk", RT, 3'b000, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
